maq_h: RTL

Hours stage of the digital-clock time chain: consumes the hour-carry strobe produced by the minutes counter and keeps a 24-hour BCD hour count (00–23). It presents that count on registered BCD outputs in 24 h or 12 h AM/PM format and emits a day-carry strobe on wrap. It also provides a manual set mode, with a single-step button and hold-to-repeat.

---
 rtl/maq_relogio_pkg.sv | 41 ++++
 rtl/maq_h_conv_12h.sv | 41 ++++
 rtl/maq_h.sv | 110 +++++++++++
 3 files changed

// File: rtl/maq_relogio_pkg.sv
// Shared types and helpers for the digital-clock time chain (hours, minutes, seconds).
package maq_relogio_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_IDLE = 2'd1,
        SET_HOLD = 2'd2
    } maq_estado_t;

    typedef logic [3:0] bcd_lsd_t;     // units digit, any stage
    typedef logic [1:0] bcd_h_msd_t;   // hour tens digit (0-2)
    typedef logic [2:0] bcd_ms_msd_t;  // minute/second tens digit (0-5)

    localparam bcd_h_msd_t HORA_MAX_MSD = 2'd2;
    localparam bcd_lsd_t   HORA_MAX_LSD = 4'd3;

    typedef struct packed {
        bcd_h_msd_t msd;
        bcd_lsd_t   lsd;
    } hora_bcd_t;

    function automatic logic hora_fim(input hora_bcd_t h);
        return (h.msd == HORA_MAX_MSD) && (h.lsd == HORA_MAX_LSD);
    endfunction

    // Next hour in 24 h BCD: 23 wraps to 00, units 9 carries into tens
    function automatic hora_bcd_t hora_inc(input hora_bcd_t h);
        hora_bcd_t r;
        if (hora_fim(h)) begin
            r = '0;
        end else if (h.lsd == 4'd9) begin
            r.msd = h.msd + 2'd1;
            r.lsd = 4'd0;
        end else begin
            r.msd = h.msd;
            r.lsd = h.lsd + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/maq_h_conv_12h.sv
// Maps the 24 h BCD hour count to display digits and PM flag for the selected mode.
module maq_h_conv_12h
    import maq_relogio_pkg::*;
(
    input  hora_bcd_t  hora,
    input  logic       modo_12h,
    output bcd_h_msd_t msd_c,
    output bcd_lsd_t   lsd_c,
    output logic       pm_c
);

    logic [4:0] bin;
    logic [4:0] bin12;

    always_comb begin
        bin   = 5'(hora.msd) * 5'd10 + 5'(hora.lsd);
        bin12 = bin;
        pm_c  = 1'b0;
        msd_c = hora.msd;
        lsd_c = hora.lsd;
        if (modo_12h) begin
            // 00 shows as 12 AM; 13-23 fold down to 01-11 PM
            if (bin == 5'd0) begin
                bin12 = 5'd12;
            end else if (bin >= 5'd12) begin
                pm_c = 1'b1;
                if (bin > 5'd12) begin
                    bin12 = bin - 5'd12;
                end
            end
            if (bin12 >= 5'd10) begin
                msd_c = 2'd1;
                lsd_c = 4'(bin12 - 5'd10);
            end else begin
                msd_c = 2'd0;
                lsd_c = 4'(bin12);
            end
        end
    end

endmodule

// File: rtl/maq_h.sv
// Hours stage: 24 h BCD hour counter with day carry, 12/24 h display and manual set with auto-repeat.
module maq_h
    import maq_relogio_pkg::*;
#(
    parameter int unsigned RESET_HOUR   = 0,
    parameter int unsigned REPEAT_TICKS = 2
) (
    input  logic       maq_h_clock,
    input  logic       maq_h_reset,
    input  logic       maq_h_enable1hz,
    input  logic       maq_h_incremento_hora,
    input  logic       maq_h_modo_12h,
    input  logic       maq_h_ajuste,
    input  logic       maq_h_botao,
    output logic [3:0] maq_h_bcd_h_lsd,
    output logic [1:0] maq_h_bcd_h_msd,
    output logic       maq_h_pm,
    output logic       maq_h_incremento_dia
);

    localparam int unsigned HOLD_W = (REPEAT_TICKS < 1) ? 1 : $clog2(REPEAT_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(REPEAT_TICKS);
    localparam hora_bcd_t         RESET_BCD  = {2'(RESET_HOUR / 10), 4'(RESET_HOUR % 10)};
    localparam logic              RESET_PM   = (RESET_HOUR >= 12);

    maq_estado_t       estado;
    hora_bcd_t         hora;
    hora_bcd_t         hora_prox;
    logic [HOLD_W-1:0] hold_cnt;
    logic              botao_prev;
    logic              botao_sobe;
    bcd_h_msd_t        disp_msd_c;
    bcd_lsd_t          disp_lsd_c;
    logic              disp_pm_c;

    assign hora_prox  = hora_inc(hora);
    assign botao_sobe = maq_h_botao && !botao_prev;

    maq_h_conv_12h u_conv (
        .hora     (hora),
        .modo_12h (maq_h_modo_12h),
        .msd_c    (disp_msd_c),
        .lsd_c    (disp_lsd_c),
        .pm_c     (disp_pm_c)
    );

    always_ff @(posedge maq_h_clock or posedge maq_h_reset) begin
        if (maq_h_reset) begin
            estado               <= RUN;
            hora                 <= RESET_BCD;
            hold_cnt             <= '0;
            botao_prev           <= 1'b0;
            maq_h_bcd_h_msd      <= RESET_BCD.msd;
            maq_h_bcd_h_lsd      <= RESET_BCD.lsd;
            maq_h_pm             <= RESET_PM;
            maq_h_incremento_dia <= 1'b0;
        end else begin
            botao_prev      <= maq_h_botao;
            maq_h_bcd_h_msd <= disp_msd_c;
            maq_h_bcd_h_lsd <= disp_lsd_c;
            maq_h_pm        <= disp_pm_c;
            case (estado)
                RUN: begin
                    // Day carry lives from the wrap edge until the next tick
                    if (maq_h_enable1hz) begin
                        maq_h_incremento_dia <= 1'b0;
                        if (maq_h_incremento_hora) begin
                            hora <= hora_prox;
                            if (hora_fim(hora)) begin
                                maq_h_incremento_dia <= 1'b1;
                            end
                        end
                    end
                    if (maq_h_ajuste) begin
                        estado <= SET_IDLE;
                    end
                end
                SET_IDLE: begin
                    maq_h_incremento_dia <= 1'b0;
                    if (!maq_h_ajuste) begin
                        estado <= RUN;
                    end else if (botao_sobe) begin
                        hora     <= hora_prox;
                        hold_cnt <= '0;
                        estado   <= SET_HOLD;
                    end
                end
                SET_HOLD: begin
                    maq_h_incremento_dia <= 1'b0;
                    if (!maq_h_ajuste) begin
                        estado <= RUN;
                    end else if (!maq_h_botao) begin
                        estado <= SET_IDLE;
                    end else if (maq_h_enable1hz) begin
                        // Counter saturates at the threshold; every tick beyond it repeats
                        if (hold_cnt >= HOLD_SAT) begin
                            hora <= hora_prox;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    estado <= RUN;
                end
            endcase
        end
    end

endmodule
